// File: rtl/rr_mux2_arbiter_if.sv
// Handshake bundle for the two-source round-robin arbiter: A and B request
// channels plus the registered output slot and its mux select.
interface rr_mux2_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sel;

  // Arbiter side: consumes both sources, produces the output slot.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, sel
  );

  // Environment side: drives the sources and the downstream ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, sel
  );
endinterface

// File: rtl/rr_mux2_arbiter.sv
// Two-source valid/ready arbiter with a burst-limited round-robin policy,
// feeding a single registered output slot that refills while it drains.
module rr_mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux2_arbiter_if.slave   bus
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  src_t             owner;
  src_t             grant;
  logic             grant_vld;
  logic [CNT_W-1:0] burst_cnt;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Slot may accept a word when empty or when it drains this same cycle.
  assign load_en = !bus.y_valid || bus.y_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    grant     = owner;
    grant_vld = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      grant_vld = 1'b1;
      grant     = (burst_cnt < BURST_MAX) ? owner
                                          : ((owner == SRC_A) ? SRC_B : SRC_A);
    end else if (bus.a_valid) begin
      grant_vld = 1'b1;
      grant     = SRC_A;
    end else if (bus.b_valid) begin
      grant_vld = 1'b1;
      grant     = SRC_B;
    end
  end

  assign xfer       = load_en && grant_vld && !rst;
  assign bus.a_ready = xfer && (grant == SRC_A);
  assign bus.b_ready = xfer && (grant == SRC_B);
  assign grant_data = (grant == SRC_B) ? bus.b_data : bus.a_data;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) begin
      bus.y_valid <= 1'b0;
      bus.y_data  <= '0;
      bus.sel     <= 1'b0;
      owner       <= SRC_A;
      burst_cnt   <= '0;
    end else if (xfer) begin
      bus.y_valid <= 1'b1;
      bus.y_data  <= grant_data;
      bus.sel     <= grant;
      if (grant == owner) begin
        burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
      end else begin
        owner     <= grant;
        burst_cnt <= CNT_W'(1);
      end
    end else if (bus.y_ready) begin
      // Drained with nothing to refill; data and select keep their last value.
      bus.y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Directed bench for rr_mux2_arbiter: BURST_LEN=2 instance for most steps,
// BURST_LEN=1 instance for the pure-alternation step.
module tb_rr_mux2_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux2_arbiter_if #(.WIDTH(8)) bus0 ();
  rr_mux2_arbiter_if #(.WIDTH(8)) bus1 ();

  rr_mux2_arbiter #(.WIDTH(8), .BURST_LEN(2), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  rr_mux2_arbiter #(.WIDTH(8), .BURST_LEN(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Contested burst with BURST_LEN=2: grant order A,A,B,B,A,A.
  logic [7:0] a_tab  [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3};
  logic [7:0] b_tab  [6] = '{8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB2};
  logic [7:0] y_tab  [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
  logic       s_tab  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus0.a_valid = 1'b1; bus0.a_data = 8'h55;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h66;
    bus0.y_ready = 1'b1;
    bus1.a_valid = 1'b0; bus1.a_data = 8'h00;
    bus1.b_valid = 1'b0; bus1.b_data = 8'h00;
    bus1.y_ready = 1'b1;

    // 1: reset with both sources valid
    #1;
    check("rst_a_ready", bus0.a_ready, 0);
    check("rst_b_ready", bus0.b_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_y_valid", bus0.y_valid, 0);
      check("rst_y_data",  bus0.y_data,  8'h00);
      check("rst_sel",     bus0.sel,     0);
      check("rst_a_ready_hold", bus0.a_ready, 0);
      check("rst_b_ready_hold", bus0.b_ready, 0);
    end
    rst = 1'b0;
    #1;
    check("rel_a_ready", bus0.a_ready, 1);
    check("rel_b_ready", bus0.b_ready, 0);
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;
    tick();
    check("idle_y_valid", bus0.y_valid, 0);

    // 2: single source A
    bus0.a_valid = 1'b1; bus0.a_data = 8'h11;
    #1;
    check("a_only_a_ready", bus0.a_ready, 1);
    check("a_only_b_ready", bus0.b_ready, 0);
    tick();
    check("a_only_y_valid", bus0.y_valid, 1);
    check("a_only_y_data",  bus0.y_data,  8'h11);
    check("a_only_sel",     bus0.sel,     0);
    bus0.a_valid = 1'b0;
    #1;
    check("a_off_a_ready", bus0.a_ready, 0);
    tick();
    check("a_off_y_valid", bus0.y_valid, 0);
    check("a_off_y_hold",  bus0.y_data,  8'h11);

    // 3: contested burst, BURST_LEN=2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus0.a_valid = 1'b1; bus0.a_data = a_tab[i];
      bus0.b_valid = 1'b1; bus0.b_data = b_tab[i];
      #1;
      check("burst_a_ready", bus0.a_ready, !s_tab[i]);
      check("burst_b_ready", bus0.b_ready, s_tab[i]);
      tick();
      check("burst_y_valid", bus0.y_valid, 1);
      check("burst_y_data",  bus0.y_data,  y_tab[i]);
      check("burst_sel",     bus0.sel,     s_tab[i]);
    end
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;

    // 4: backpressure then same-cycle refill
    do_reset();
    bus0.a_valid = 1'b1; bus0.a_data = 8'h22;
    tick();
    check("bp_load_y_data", bus0.y_data, 8'h22);
    bus0.y_ready = 1'b0;
    bus0.a_data = 8'h33;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_a_ready", bus0.a_ready, 0);
      check("bp_b_ready", bus0.b_ready, 0);
      tick();
      check("bp_y_valid", bus0.y_valid, 1);
      check("bp_y_data",  bus0.y_data,  8'h22);
      check("bp_sel",     bus0.sel,     0);
    end
    bus0.y_ready = 1'b1;
    #1;
    check("refill_a_ready", bus0.a_ready, 1);
    tick();
    check("refill_y_valid", bus0.y_valid, 1);
    check("refill_y_data",  bus0.y_data,  8'h33);
    check("refill_sel",     bus0.sel,     0);
    #1;
    check("refill2_b_ready", bus0.b_ready, 1);
    tick();
    check("refill2_y_data", bus0.y_data, 8'h44);
    check("refill2_sel",    bus0.sel,    1);
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;

    // 5: reset mid-burst restores owner=A, count=0
    do_reset();
    bus0.a_valid = 1'b1; bus0.a_data = 8'h51;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h61;
    tick();
    check("mid_y_data", bus0.y_data, 8'h51);
    rst = 1'b1;
    #1;
    check("mid_rst_a_ready", bus0.a_ready, 0);
    tick();
    check("mid_rst_y_valid", bus0.y_valid, 0);
    check("mid_rst_y_data",  bus0.y_data,  8'h00);
    rst = 1'b0;
    tick();
    check("post_rst0_sel",  bus0.sel,    0);
    check("post_rst0_data", bus0.y_data, 8'h51);
    tick();
    check("post_rst1_sel",  bus0.sel,    0);
    check("post_rst1_data", bus0.y_data, 8'h51);
    tick();
    check("post_rst2_sel",  bus0.sel,    1);
    check("post_rst2_data", bus0.y_data, 8'h61);
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;

    // 6: BURST_LEN=1 alternation, then B alone
    bus1.a_valid = 1'b1; bus1.a_data = 8'h71;
    bus1.b_valid = 1'b1; bus1.b_data = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_y_valid", bus1.y_valid, 1);
      check("alt_sel",     bus1.sel,     (i % 2));
    end
    bus1.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus1.b_data = 8'h90 + 8'(i);
      tick();
      check("b_only_y_valid", bus1.y_valid, 1);
      check("b_only_sel",     bus1.sel,     1);
      check("b_only_y_data",  bus1.y_data,  8'h90 + 8'(i));
    end
    bus1.b_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
